rom_fetch_ctrl: RTL and testbench
=================================

// Module: rom_fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the 4k x 8 program ROM (12-bit address, 8-bit data, combinational read).
//  Owns the program counter, drives the ROM address and captures each byte into an instruction register (IR).
//  Presents IR as {instr[3:0], oprnd[3:0]} to the decoder over a valid/ready handshake.
//  Supports jumps and start/stop control from the core.
// PARAMETERS
//  ADDR_W    12       ROM address / PC width
//  DATA_W    8        ROM data / IR width (instr = IR[7:4], oprnd = IR[3:0])
//  RESET_PC  12'h000  PC value after reset
//  WAIT_CYC  2        ROM wait states (1..15); used only with ROM_WAIT_EN
// PORTS
//  clk       in   1       rising-edge clock
//  reset     in   1       synchronous, active-high reset
//  enable    in   1       1 = run fetches; 0 = stop issuing new fetches
//  jmp_en    in   1       load PC from jmp_addr, flush IR (1-cycle pulse)
//  jmp_addr  in   ADDR_W  jump target
//  rom_data  in   DATA_W  ROM read data (combinational from rom_addr)
//  rom_addr  out  ADDR_W  ROM address; equals pc at all times
//  pc        out  ADDR_W  current program counter (next byte to fetch)
//  ir_valid  out  1       IR holds an unconsumed instruction
//  ir_ready  in   1       decoder accepts IR this cycle when ir_valid=1
//  instr     out  4       IR[7:4]
//  oprnd     out  4       IR[3:0]
// BEHAVIOUR
//  - Reset: pc=RESET_PC, IR=8'h00, ir_valid=0, state=IDLE, wait counter=0. Reset overrides all inputs,
//    including mid-fetch and mid-handshake.
//  - States: IDLE, FETCH, VALID (plus WAIT with ROM_WAIT_EN).
//  - IDLE: enable=1 -> FETCH next cycle; no capture in IDLE.
//  - FETCH: at clock edge IR<=rom_data (addr=pc), pc<=pc+1, ir_valid<=1, -> VALID. Latency: 1 cycle
//    in FETCH, so first ir_valid 2 cycles after enable rises from IDLE.
//  - VALID: IR and ir_valid held stable while ir_ready=0. On ir_valid&ir_ready:
//      enable=1 -> IR<=rom_data, pc<=pc+1, stay VALID (back-to-back, 1 instr/cycle);
//      enable=0 -> ir_valid<=0, -> IDLE, pc unchanged.
//  - enable=0 in FETCH -> IDLE, no capture, pc unchanged. enable=0 never drops a held IR.
//  - jmp_en (any state except reset): pc<=jmp_addr, ir_valid<=0 (IR discarded even if ir_ready=1
//    same cycle, i.e. not consumed), -> FETCH if enable=1 else IDLE. Priority: reset > jmp_en > handshake.
//  - PC arithmetic mod 2^ADDR_W: 12'hFFF+1 -> 12'h000, no flag.
//  - rom_addr is combinational from pc register; no other outputs are combinational.
// CONFIGURATION
//  ROM_WAIT_EN defined: every capture preceded by WAIT state lasting WAIT_CYC cycles (counter loads
//   WAIT_CYC-1, counts to 0, then -> FETCH). VALID handshake with enable=1 -> WAIT instead of
//   capturing in place; throughput 1 instr per WAIT_CYC+2 cycles. jmp_en/enable=0 in WAIT abort
//   the wait as in FETCH. rom_addr stable = pc throughout WAIT.
//  ROM_WAIT_EN undefined: no WAIT state or counter; behaviour exactly as above, WAIT_CYC ignored.
// STRUCTURE
//  - Shared header rom_fetch_defs.vh: ADDR_W/DATA_W defaults, state encodings
//    (S_IDLE=2'd0, S_FETCH=2'd1, S_VALID=2'd2, S_WAIT=2'd3), IR field slice positions.
//  - One sub-module: pc_counter (ADDR_W-bit, sync reset to RESET_PC, ld has priority over inc).
//  - FSM, IR and handshake logic stay in rom_fetch_ctrl.
// TESTING (ROM preloaded: [000]=A5 [001]=3C [002]=F0 [100]=81 [FFF]=7E)
//  1 reset, enable=1, ir_ready=1 -> ir_valid at cycle 2 with instr=A oprnd=5; then 3C, F0 on
//    consecutive cycles; pc=003 after third capture.
//  2 ir_ready=0 for 5 cycles after first capture -> IR=A5, ir_valid=1, pc=001 held stable; ready
//    pulse -> IR=3C next cycle.
//  3 jmp_en with jmp_addr=100 while ir_valid=1, ir_ready=1 -> A5 not consumed, ir_valid=0 next
//    cycle, then IR=81, pc=101.
//  4 jmp_addr=FFF, run two fetches -> IR=7E then IR=A5, pc wraps FFF->000->001.
//  5 enable dropped in VALID with ir_ready=0 -> IR held; on ready -> ir_valid=0, IDLE, pc frozen;
//    enable=1 resumes from same pc.
//  6 reset asserted in FETCH and in VALID -> next cycle pc=000, ir_valid=0, IR=00; with
//    ROM_WAIT_EN, WAIT_CYC=2: capture spacing = 4 cycles, rom_addr constant during WAIT.

Source files
------------

// File: rtl/rom_fetch_ctrl_pkg.sv
// Shared definitions for the ROM instruction-fetch sequencer:
// default widths, FSM state encoding and IR field positions.
package rom_fetch_ctrl_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;

  localparam int INSTR_MSB = 7;
  localparam int INSTR_LSB = 4;
  localparam int OPRND_MSB = 3;
  localparam int OPRND_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/rom_fetch_ctrl_if.sv
// ROM read bus plus the IR valid/ready handshake toward the decoder.
// The fetch controller is the master; the ROM/decoder side is the slave.
interface rom_fetch_ctrl_if
  import rom_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              ir_valid;
  logic              ir_ready;
  logic [3:0]        instr;
  logic [3:0]        oprnd;

  modport master (
    output rom_addr, ir_valid, instr, oprnd,
    input  rom_data, ir_ready
  );

  modport slave (
    input  rom_addr, ir_valid, instr, oprnd,
    output rom_data, ir_ready
  );
endinterface

// File: rtl/rom_fetch_ctrl_pc_counter.sv
// Program counter with synchronous reset; a load takes priority over increment.
module pc_counter #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic [ADDR_W-1:0] ld_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);
  logic [ADDR_W-1:0] pc_q, pc_d;

  // Increment wraps modulo 2^ADDR_W without a flag.
  always_comb begin
    pc_d = pc_q;
    if (ld)       pc_d = ld_val;
    else if (inc) pc_d = pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign pc = pc_q;
endmodule

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, captures ROM bytes into IR and
// hands them to the decoder. Define ROM_WAIT_EN to insert WAIT_CYC wait states.
module rom_fetch_ctrl
  import rom_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [ADDR_W-1:0] pc,
  rom_fetch_ctrl_if.master  bus
);
  if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_wait_cyc_chk
    $error("WAIT_CYC must be in 1..15");
  end

`ifdef ROM_WAIT_EN
  localparam state_e    FETCH_ENTRY = S_WAIT;
  localparam logic [3:0] WAIT_LD    = 4'(WAIT_CYC - 1);
  logic [3:0] wait_cnt_q, wait_cnt_d;
`else
  localparam state_e FETCH_ENTRY = S_FETCH;
`endif

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              valid_q, valid_d;
  logic              pc_ld, pc_inc;

  pc_counter #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .reset  (reset),
    .ld     (pc_ld),
    .ld_val (jmp_addr),
    .inc    (pc_inc),
    .pc     (pc)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
`ifdef ROM_WAIT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    // A jump discards IR even if the decoder is accepting it this cycle.
    if (jmp_en) begin
      pc_ld   = 1'b1;
      valid_d = 1'b0;
      state_d = enable ? FETCH_ENTRY : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable) state_d = FETCH_ENTRY;
        end
        S_FETCH: begin
          if (!enable) begin
            state_d = S_IDLE;
          end else begin
            ir_d    = bus.rom_data;
            pc_inc  = 1'b1;
            valid_d = 1'b1;
            state_d = S_VALID;
          end
        end
        S_VALID: begin
          if (valid_q && bus.ir_ready) begin
            if (enable) begin
`ifdef ROM_WAIT_EN
              valid_d = 1'b0;
              state_d = S_WAIT;
`else
              ir_d   = bus.rom_data;
              pc_inc = 1'b1;
`endif
            end else begin
              valid_d = 1'b0;
              state_d = S_IDLE;
            end
          end
        end
        default: begin
`ifdef ROM_WAIT_EN
          if (!enable)                state_d = S_IDLE;
          else if (wait_cnt_q == '0)  state_d = S_FETCH;
`else
          state_d = S_IDLE;
`endif
        end
      endcase
    end
`ifdef ROM_WAIT_EN
    if (state_d == S_WAIT && (state_q != S_WAIT || jmp_en))
      wait_cnt_d = WAIT_LD;
    else if (state_q == S_WAIT && wait_cnt_q != '0)
      wait_cnt_d = wait_cnt_q - 4'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

`ifdef ROM_WAIT_EN
  always_ff @(posedge clk) begin
    if (reset) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end
`endif

  assign bus.rom_addr = pc;
  assign bus.ir_valid = valid_q;
  assign bus.instr    = ir_q[INSTR_MSB:INSTR_LSB];
  assign bus.oprnd    = ir_q[OPRND_MSB:OPRND_LSB];
endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed bench for rom_fetch_ctrl against a preloaded 4k x 8 ROM model.
module tb_rom_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        jmp_en;
  logic [11:0] jmp_addr;
  logic [11:0] pc;
  logic [7:0]  rom [0:4095];
  int          n_vec = 0;
  int          n_err = 0;

  rom_fetch_ctrl_if #(.ADDR_W(12), .DATA_W(8)) bus ();

  rom_fetch_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .jmp_en   (jmp_en),
    .jmp_addr (jmp_addr),
    .pc       (pc),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_data = rom[bus.rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {ir_valid, instr, oprnd, pc}
  function automatic logic [31:0] obs();
    return {11'd0, bus.ir_valid, bus.instr, bus.oprnd, pc};
  endfunction

  function automatic logic [31:0] st(input logic v, input logic [7:0] ir, input logic [11:0] p);
    return {11'd0, v, ir, p};
  endfunction

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; jmp_en = 1'b0; bus.ir_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h000] = 8'hA5; rom[12'h001] = 8'h3C; rom[12'h002] = 8'hF0;
    rom[12'h100] = 8'h81; rom[12'hFFF] = 8'h7E;
    jmp_addr = 12'h000;

    do_reset();
    check("reset_state", obs(), st(0, 8'h00, 12'h000));
    check("reset_romaddr", 32'(bus.rom_addr), 32'h000);

`ifdef ROM_WAIT_EN
    enable = 1'b1; bus.ir_ready = 1'b1;
    tick(); check("w_wait1", obs(), st(0, 8'h00, 12'h000));
    check("w_addr1", 32'(bus.rom_addr), 32'h000);
    tick(); check("w_wait2", obs(), st(0, 8'h00, 12'h000));
    check("w_addr2", 32'(bus.rom_addr), 32'h000);
    tick(); check("w_fetch", obs(), st(0, 8'h00, 12'h000));
    tick(); check("w_cap1", obs(), st(1, 8'hA5, 12'h001));
    tick(); check("w_drop", obs(), st(0, 8'hA5, 12'h001));
    check("w_addr3", 32'(bus.rom_addr), 32'h001);
    tick(); check("w_hold", obs(), st(0, 8'hA5, 12'h001));
    tick(); check("w_fetch2", obs(), st(0, 8'hA5, 12'h001));
    tick(); check("w_cap2", obs(), st(1, 8'h3C, 12'h002));
    reset = 1'b1;
    tick(); reset = 1'b0;
    check("w_rst", obs(), st(0, 8'h00, 12'h000));
`else
    // 1: back-to-back fetch
    enable = 1'b1; bus.ir_ready = 1'b1;
    tick(); check("t1_fetch", obs(), st(0, 8'h00, 12'h000));
    tick(); check("t1_cap_a5", obs(), st(1, 8'hA5, 12'h001));
    tick(); check("t1_cap_3c", obs(), st(1, 8'h3C, 12'h002));
    tick(); check("t1_cap_f0", obs(), st(1, 8'hF0, 12'h003));
    check("t1_romaddr", 32'(bus.rom_addr), 32'h003);

    // 2: decoder stall
    do_reset();
    enable = 1'b1;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_stall", obs(), st(1, 8'hA5, 12'h001));
      tick();
    end
    check("t2_stall_end", obs(), st(1, 8'hA5, 12'h001));
    bus.ir_ready = 1'b1;
    tick(); bus.ir_ready = 1'b0;
    check("t2_ready", obs(), st(1, 8'h3C, 12'h002));

    // 3: jump flushes an IR offered on the same cycle
    do_reset();
    enable = 1'b1; bus.ir_ready = 1'b1;
    tick(); tick();
    check("t3_pre", obs(), st(1, 8'hA5, 12'h001));
    jmp_en = 1'b1; jmp_addr = 12'h100;
    tick(); jmp_en = 1'b0;
    check("t3_flush", {31'd0, bus.ir_valid}, 32'd0);
    check("t3_pc", 32'(pc), 32'h100);
    tick(); check("t3_cap81", obs(), st(1, 8'h81, 12'h101));

    // 4: PC wrap
    jmp_en = 1'b1; jmp_addr = 12'hFFF;
    tick(); jmp_en = 1'b0;
    check("t4_jmp", obs(), st(0, 8'h81, 12'hFFF));
    tick(); check("t4_cap7e", obs(), st(1, 8'h7E, 12'h000));
    tick(); check("t4_capa5", obs(), st(1, 8'hA5, 12'h001));

    // 5: enable dropped while IR held
    bus.ir_ready = 1'b0; enable = 1'b0;
    tick(); check("t5_hold1", obs(), st(1, 8'hA5, 12'h001));
    tick(); check("t5_hold2", obs(), st(1, 8'hA5, 12'h001));
    bus.ir_ready = 1'b1;
    tick(); check("t5_consume", obs(), st(0, 8'hA5, 12'h001));
    tick(); check("t5_idle", obs(), st(0, 8'hA5, 12'h001));
    enable = 1'b1;
    tick(); check("t5_fetch", obs(), st(0, 8'hA5, 12'h001));
    tick(); check("t5_resume", obs(), st(1, 8'h3C, 12'h002));

    // 6: reset in FETCH and in VALID, enable drop in FETCH
    do_reset();
    enable = 1'b1;
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    check("t6_rst_fetch", obs(), st(0, 8'h00, 12'h000));
    tick(); tick();
    check("t6_pre_valid", obs(), st(1, 8'hA5, 12'h001));
    reset = 1'b1; bus.ir_ready = 1'b1;
    tick(); reset = 1'b0; enable = 1'b0; bus.ir_ready = 1'b0;
    check("t6_rst_valid", obs(), st(0, 8'h00, 12'h000));
    enable = 1'b1;
    tick(); enable = 1'b0;
    tick(); check("t6_fetch_abort", obs(), st(0, 8'h00, 12'h000));
    tick(); check("t6_idle_stay", obs(), st(0, 8'h00, 12'h000));
    jmp_en = 1'b1; jmp_addr = 12'h002;
    tick(); jmp_en = 1'b0;
    check("t6_jmp_idle", obs(), st(0, 8'h00, 12'h002));
    tick(); check("t6_idle_after_jmp", obs(), st(0, 8'h00, 12'h002));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
